// File: rtl/fma_pkg.sv
// -----------------------------------------------------------------------------
// fma_pkg
// Shared definitions for the FMA operand read buffer and the FMA write buffer.
// A memory line carries FMA_COUNT lanes of three phrases (a | b | c). Phrase p,
// lane i occupies line bits [(p*FMA_COUNT + i)*WORD_WIDTH +: WORD_WIDTH].
// Both buffers slice lines through phrase_word(), so the read and write paths
// cannot disagree on the layout.
// -----------------------------------------------------------------------------
package fma_pkg;

  localparam int WORD_WIDTH = 16;
  localparam int FMA_COUNT  = 2;
  localparam int LINE_WIDTH = WORD_WIDTH * FMA_COUNT * 3;

  localparam int PHRASE_A = 0;
  localparam int PHRASE_B = 1;
  localparam int PHRASE_C = 2;

  // Extract one operand word (phrase, lane) from a packed memory line.
  function automatic logic [WORD_WIDTH-1:0] phrase_word(
    input logic [LINE_WIDTH-1:0] line,
    input int                    phrase,
    input int                    lane
  );
    return line[(phrase * FMA_COUNT + lane) * WORD_WIDTH +: WORD_WIDTH];
  endfunction

endpackage

// File: rtl/line_fifo.sv
// -----------------------------------------------------------------------------
// line_fifo
// Generic synchronous first-word-fall-through FIFO with an occupancy count.
// The head entry is visible on rd_data_o whenever count_o is non-zero.
// Full/empty are derived from the registered count only, never from pointer
// comparison, so pointers simply wrap modulo DEPTH (a power of two).
//
// Ports
//   clk_i      clock
//   rst_i      synchronous active-high reset (clears pointers, count, storage)
//   push_i     write request; honoured only when not full
//   wr_data_i  data written on an accepted push
//   pop_i      read request; honoured only when not empty
//   rd_data_o  head entry (stale contents when empty -- caller gates)
//   ready_o    not full, from registered count only
//   count_o    entries held
// -----------------------------------------------------------------------------
module line_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     ready_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push_ok;
  logic pop_ok;

  // A full FIFO refuses a push even if it pops in the same cycle: ready has
  // no combinational path from the consumer side.
  assign push_ok = push_i && (count_q != CNT_W'(DEPTH));
  assign pop_ok  = pop_i  && (count_q != '0);

  // NOTE: every variable assigned here gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Storage is
  // cleared on reset here because the line layout is tiny and a reset must
  // leave no stale operands anywhere in the buffer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign ready_o   = (count_q != CNT_W'(DEPTH));
  assign count_o   = count_q;

endmodule

// File: rtl/fma_read_buffer.sv
// -----------------------------------------------------------------------------
// fma_read_buffer
// Queues whole operand lines read from the operand BRAM and presents the a, b
// and c operands of every FMA lane in parallel to the FMA bank, FWFT style.
// Each line is stored together with a per-lane valid mask; the head mask drives
// the FMA-side valid. When the queue is empty all operand and valid outputs
// are forced to zero.
//
// Ports
//   clk_in          clock
//   rst_in          synchronous active-high reset, discards all queued lines
//   line_in         packed line (a | b | c phrases, FMA_COUNT lanes each)
//   line_mask_in    per-lane valid mask stored with the line
//   line_valid_in   line_in valid this cycle
//   line_ready_out  buffer can accept a line (registered count only)
//   a_out/b_out/c_out  operands, lane i at [i*WORD_WIDTH +: WORD_WIDTH]
//   fma_valid_in    per-lane operand valid toward the FMA bank (output)
//   fma_ready       FMA bank consumes the head line this cycle
//   count_out       entries held
// -----------------------------------------------------------------------------
module fma_read_buffer
  import fma_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic [LINE_WIDTH-1:0]           line_in,
  input  logic [FMA_COUNT-1:0]            line_mask_in,
  input  logic                            line_valid_in,
  output logic                            line_ready_out,
  output logic [WORD_WIDTH*FMA_COUNT-1:0] a_out,
  output logic [WORD_WIDTH*FMA_COUNT-1:0] b_out,
  output logic [WORD_WIDTH*FMA_COUNT-1:0] c_out,
  output logic [FMA_COUNT-1:0]            fma_valid_in,
  input  logic                            fma_ready,
  output logic [$clog2(DEPTH):0]          count_out
);

  localparam int ENTRY_W = LINE_WIDTH + FMA_COUNT;

  logic [ENTRY_W-1:0]          head_entry;
  logic [LINE_WIDTH-1:0]       head_line;
  logic [FMA_COUNT-1:0]        head_mask;
  logic                        non_empty;
  logic                        pop;
  logic [$clog2(DEPTH):0]      count;

  line_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_line_fifo (
    .clk_i     (clk_in),
    .rst_i     (rst_in),
    .push_i    (line_valid_in),
    .wr_data_i ({line_in, line_mask_in}),
    .pop_i     (pop),
    .rd_data_o (head_entry),
    .ready_o   (line_ready_out),
    .count_o   (count)
  );

  assign head_line = head_entry[ENTRY_W-1 -: LINE_WIDTH];
  assign head_mask = head_entry[FMA_COUNT-1:0];
  assign non_empty = (count != '0);
  assign count_out = count;

  // Popped entries stay in storage, so the empty case must be gated to zero.
  assign fma_valid_in = non_empty ? head_mask : '0;

  // A line whose mask is all zero is never offered and therefore never popped.
  assign pop = (fma_valid_in != '0) && fma_ready;

  for (genvar i = 0; i < FMA_COUNT; i++) begin : g_lane
    assign a_out[i*WORD_WIDTH +: WORD_WIDTH] =
      non_empty ? phrase_word(head_line, PHRASE_A, i) : '0;
    assign b_out[i*WORD_WIDTH +: WORD_WIDTH] =
      non_empty ? phrase_word(head_line, PHRASE_B, i) : '0;
    assign c_out[i*WORD_WIDTH +: WORD_WIDTH] =
      non_empty ? phrase_word(head_line, PHRASE_C, i) : '0;
  end

endmodule
